regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Drives the register file write port (regWriteAddr/dataToWrite/toWrite) from
//   two producers: the single-cycle ALU result path and the multi-cycle load path.
//   Load results are buffered in a FIFO while the ALU uses the port. A pending-
//   write scoreboard tells decode which registers have an outstanding write.
// PARAMETERS
//   WORD_WIDTH   32  data width, equal to the register file word width
//   FIFO_DEPTH   4   load-result FIFO entries; a power of two, >= 2
//   STARVE_LIMIT 8   cycles the FIFO may stay full and unserved before aluHold
// PORTS
//   clk           in   1           clock; all state updates on posedge
//   rst           in   1           synchronous reset, active-high
//   aluValid      in   1           ALU result valid; never back-pressured
//   aluAddr       in   5           ALU destination register
//   aluData       in   WORD_WIDTH  ALU result
//   aluHold       out  1           request: upstream must drop aluValid next cycle
//   memValid      in   1           load result valid
//   memReady      out  1           FIFO can accept; transfer = memValid & memReady
//   memAddr       in   5           load destination register
//   memData       in   WORD_WIDTH  load result
//   issueValid    in   1           decode issued an instruction that writes issueAddr
//   issueAddr     in   5           register to mark pending
//   regWriteAddr  out  5           to register file write address
//   dataToWrite   out  WORD_WIDTH  to register file write data
//   toWrite       out  1           to register file write enable
//   pendingMask   out  32          bit r = 1: register r has an outstanding write
//   fifoCount     out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//   - Reset (rst high at posedge): toWrite=0, regWriteAddr=0, dataToWrite=0,
//     pendingMask=0, fifoCount=0, aluHold=0, starve counter=0. FIFO pointers=0.
//   - memReady = !rst && (fifoCount < FIFO_DEPTH), from registered count only. A
//     pop in the same cycle does not raise memReady.
//   - Enqueue on memValid & memReady when memAddr != 0. A transfer with memAddr == 0
//     completes the handshake and is discarded.
//   - Selection each cycle: if aluValid && aluAddr != 0, the ALU wins. Else, if the
//     FIFO is non-empty, pop the head. Else, no write.
//   - All write-port outputs are registered. The selected write appears with
//     toWrite=1 on the next cycle. toWrite=0 on cycles with no selection, and
//     addr/data then hold their previous values.
//   - Latency:
//     - ALU: aluValid in cycle t gives toWrite in t+1.
//     - Load, FIFO empty, no ALU: transfer in t gives toWrite in t+2.
//     - A same-cycle enqueue and pop of the same entry is not allowed. There is
//       no bypass.
//   - aluValid with aluAddr == 0 is dropped and does not block the FIFO pop.
//   - Ordering is preserved within each source. There is no ordering guarantee
//     between ALU and load results.
//   - Starvation:
//     - The counter increments each cycle where fifoCount == FIFO_DEPTH and the
//       ALU wins. It clears on any pop.
//     - aluHold is registered. It rises when the counter reaches STARVE_LIMIT and
//       falls on the cycle after the next pop.
//     - If aluValid stays high while aluHold is asserted, the ALU still wins
//       (protocol violation; flagged by an assertion, not by the RTL).
//   - Scoreboard: pendingMask[r] sets on issueValid && issueAddr == r != 0. It
//     clears on the edge that drives toWrite=1 with regWriteAddr == r. If set and
//     clear hit the same r in one cycle, set wins. pendingMask[0] is always 0.
//   - fifoCount: +1 on enqueue, -1 on pop, unchanged on both. It never exceeds
//     FIFO_DEPTH or wraps below 0. Pointers wrap modulo FIFO_DEPTH.
//   - Reset mid-operation: FIFO contents and pending bits are lost, and no write
//     issues in the cycle after the rst edge.
// TESTING
//   1. ALU only: aluValid, aluAddr=8, aluData=32'h1234 at t -> t+1: toWrite=1,
//      regWriteAddr=8, dataToWrite=32'h1234; t+2: toWrite=0.
//   2. Load behind ALU: ALU writes 9/10 at t, t+1; load 11=32'hBEEF at t ->
//      order 9, 10, 11, with 11 at t+3; fifoCount 1,1,0.
//   3. Fill FIFO: 4 loads with ALU busy -> memReady=0 at fifoCount=4; a 5th
//      memValid stalls and its data is not lost; pops drain in FIFO order.
//   4. Starvation: FIFO full, ALU valid every cycle -> aluHold=1 after 8 cycles;
//      ALU drops -> head popped, aluHold=0 the following cycle.
//   5. $0 handling: aluAddr=0 plus FIFO non-empty -> the FIFO pops the same cycle;
//      memAddr=0 -> memReady handshake completes, fifoCount unchanged.
//   6. Scoreboard: issue 12 at t -> pendingMask[12]=1 at t+1. A write to 12 and a
//      re-issue of 12 in the same cycle leave the bit at 1. rst mid-stream -> all
//      outputs return to reset values.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// Module : regfile_write_arbiter_if
// Brief  : ALU / load / issue inputs and register-file write-port outputs
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_write_arbiter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  aluValid;
  logic [4:0]            aluAddr;
  logic [WORD_WIDTH-1:0] aluData;
  logic                  aluHold;
  logic                  memValid;
  logic                  memReady;
  logic [4:0]            memAddr;
  logic [WORD_WIDTH-1:0] memData;
  logic                  issueValid;
  logic [4:0]            issueAddr;
  logic [4:0]            regWriteAddr;
  logic [WORD_WIDTH-1:0] dataToWrite;
  logic                  toWrite;
  logic [31:0]           pendingMask;
  logic [c_CNT_W-1:0]    fifoCount;

  modport master (
    output aluValid, aluAddr, aluData, memValid, memAddr, memData, issueValid, issueAddr,
    input  aluHold, memReady, regWriteAddr, dataToWrite, toWrite, pendingMask, fifoCount
  );

  modport slave (
    input  aluValid, aluAddr, aluData, memValid, memAddr, memData, issueValid, issueAddr,
    output aluHold, memReady, regWriteAddr, dataToWrite, toWrite, pendingMask, fifoCount
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// Module : regfile_write_arbiter
// Brief  : Register-file write port arbiter: ALU priority, buffered loads,
//          starvation hold and pending-write scoreboard
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_write_arbiter #(
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  regfile_write_arbiter_if.slave     bus
);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);

  logic [4:0]            fifo_addr_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0]    count_q, count_d;
  logic [c_STV_W-1:0]    starve_q, starve_d;
  logic                  hold_q;
  logic                  to_write_q;
  logic [4:0]            wr_addr_q;
  logic [WORD_WIDTH-1:0] wr_data_q;
  logic [31:0]           pending_q, pending_d;

  logic                  w_full, w_enq, w_alu_win, w_pop, w_sel_valid;
  logic [4:0]            w_sel_addr;
  logic [WORD_WIDTH-1:0] w_sel_data;

  assign w_full       = (count_q == c_FULL);
  // Readiness comes from the registered count only: a pop this cycle frees no slot yet.
  assign bus.memReady = !rst && !w_full;
  assign w_enq        = bus.memValid && bus.memReady && (bus.memAddr != 5'd0);
  assign w_alu_win    = bus.aluValid && (bus.aluAddr != 5'd0);
  assign w_pop        = !w_alu_win && (count_q != '0);
  assign w_sel_valid  = w_alu_win || w_pop;
  assign w_sel_addr   = w_alu_win ? bus.aluAddr : fifo_addr_q[rd_ptr_q];
  assign w_sel_data   = w_alu_win ? bus.aluData : fifo_data_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({w_enq, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (w_pop)
      starve_d = '0;
    else if (w_full && w_alu_win && (starve_q != c_STV_MAX))
      starve_d = starve_q + 1'b1;
  end

  // Set is applied after clear so a same-cycle re-issue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (w_sel_valid)
      pending_d[w_sel_addr] = 1'b0;
    if (bus.issueValid)
      pending_d[bus.issueAddr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      hold_q     <= 1'b0;
      to_write_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pending_q  <= '0;
    end else begin
      if (w_enq)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      starve_q   <= starve_d;
      hold_q     <= (starve_d == c_STV_MAX);
      to_write_q <= w_sel_valid;
      if (w_sel_valid) begin
        wr_addr_q <= w_sel_addr;
        wr_data_q <= w_sel_data;
      end
      pending_q  <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      fifo_addr_q[wr_ptr_q] <= bus.memAddr;
      fifo_data_q[wr_ptr_q] <= bus.memData;
    end
  end

  assign bus.aluHold      = hold_q;
  assign bus.toWrite      = to_write_q;
  assign bus.regWriteAddr = wr_addr_q;
  assign bus.dataToWrite  = wr_data_q;
  assign bus.pendingMask  = pending_q;
  assign bus.fifoCount    = count_q;
endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// Module : tb_regfile_write_arbiter
// Brief  : Directed and random checks of regfile_write_arbiter against a queue model
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_write_arbiter;
  localparam int W   = 32;
  localparam int D   = 4;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.WORD_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  regfile_write_arbiter #(.WORD_WIDTH(W), .FIFO_DEPTH(D), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]   a;
    logic [W-1:0] d;
  } ent_t;

  ent_t         m_q[$];
  logic         m_tw;
  logic [4:0]   m_addr;
  logic [W-1:0] m_data;
  logic [31:0]  m_pend;
  int           m_starve;
  logic         m_hold;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("toWrite",      64'(bus.toWrite),      64'(m_tw));
    chk("regWriteAddr", 64'(bus.regWriteAddr), 64'(m_addr));
    chk("dataToWrite",  64'(bus.dataToWrite),  64'(m_data));
    chk("pendingMask",  64'(bus.pendingMask),  64'(m_pend));
    chk("fifoCount",    64'(bus.fifoCount),    64'(m_q.size()));
    chk("memReady",     64'(bus.memReady),     64'(!rst && (m_q.size() < D)));
    chk("aluHold",      64'(bus.aluHold),      64'(m_hold));
  endtask

  // Drive one cycle of inputs, advance the model by the same rules, then check at negedge.
  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [W-1:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [W-1:0] md,
                      input logic iv, input logic [4:0] ia, output logic fired);
    int   sz;
    logic aw, pop;
    ent_t e;
    rst = r;
    bus.aluValid = av; bus.aluAddr = aa; bus.aluData = ad;
    bus.memValid = mv; bus.memAddr = ma; bus.memData = md;
    bus.issueValid = iv; bus.issueAddr = ia;
    fired = 1'b0;
    if (r) begin
      m_q.delete();
      m_tw = 1'b0; m_addr = '0; m_data = '0; m_pend = '0; m_starve = 0; m_hold = 1'b0;
    end else begin
      sz  = m_q.size();
      aw  = av && (aa != 0);
      pop = !aw && (sz > 0);
      fired = mv && (sz < D);
      m_tw = aw || pop;
      if (aw) begin
        m_addr = aa; m_data = ad;
      end else if (pop) begin
        e = m_q.pop_front();
        m_addr = e.a; m_data = e.d;
      end
      if (fired && ma != 0) begin
        e.a = ma; e.d = md;
        m_q.push_back(e);
      end
      if (pop)                  m_starve = 0;
      else if (sz == D && aw)   m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      m_hold = (m_starve >= LIM);
      if (m_tw) m_pend[m_addr] = 1'b0;
      if (iv)   m_pend[ia] = 1'b1;
      m_pend[0] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  logic         f;
  logic         lv;
  logic [4:0]   la;
  logic [W-1:0] ld;
  logic         seen;

  initial begin
    rst = 1'b1;
    bus.aluValid = 0; bus.aluAddr = 0; bus.aluData = 0;
    bus.memValid = 0; bus.memAddr = 0; bus.memData = 0;
    bus.issueValid = 0; bus.issueAddr = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, f);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, f);

    // ALU only: write visible one cycle later, gone the cycle after
    step(0, 1, 8, 32'h1234, 0, 0, 0, 0, 0, f);
    chk("t1_tw", 64'(bus.toWrite), 64'd1);
    chk("t1_addr", 64'(bus.regWriteAddr), 64'd8);
    chk("t1_data", 64'(bus.dataToWrite), 64'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, f);
    chk("t1_idle", 64'(bus.toWrite), 64'd0);

    // Load behind two ALU writes
    step(0, 1, 9, 32'h9, 1, 11, 32'hBEEF, 0, 0, f);
    chk("t2_cnt0", 64'(bus.fifoCount), 64'd1);
    step(0, 1, 10, 32'hA, 0, 0, 0, 0, 0, f);
    chk("t2_cnt1", 64'(bus.fifoCount), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, f);
    chk("t2_cnt2", 64'(bus.fifoCount), 64'd0);
    chk("t2_addr", 64'(bus.regWriteAddr), 64'd11);
    chk("t2_data", 64'(bus.dataToWrite), 64'hBEEF);

    // Fill FIFO under a busy ALU, hold a fifth load, run into starvation
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'(1 + i), 32'(i), 1, 5'(20 + i), 32'hD000 + 32'(i), 0, 0, f);
    chk("t3_full", 64'(bus.memReady), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 1, 5, 32'h55, 1, 24, 32'hD004, 0, 0, f);
      seen = bus.aluHold;
    end
    chk("t4_hold_seen", 64'(seen), 64'd1);
    step(0, 0, 0, 0, 1, 24, 32'hD004, 0, 0, f);
    chk("t4_hold_drop", 64'(bus.aluHold), 64'd0);
    chk("t4_head", 64'(bus.regWriteAddr), 64'd20);
    lv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, lv, 24, 32'hD004, 0, 0, f);
      if (f) lv = 1'b0;
    end

    // $0 handling: ALU to r0 does not block a pop; load to r0 is discarded
    step(0, 0, 0, 0, 1, 3, 32'h33, 0, 0, f);
    step(0, 1, 0, 32'hFF, 1, 0, 32'h77, 0, 0, f);
    chk("t5_pop", 64'(bus.regWriteAddr), 64'd3);
    chk("t5_cnt", 64'(bus.fifoCount), 64'd0);

    // Scoreboard set, set-beats-clear, reset mid-stream
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, f);
    chk("t6_set", 64'(bus.pendingMask[12]), 64'd1);
    step(0, 1, 12, 32'hC, 1, 13, 32'hD, 1, 12, f);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, f);
    chk("t6_keep", 64'(bus.pendingMask[12]), 64'd1);
    step(1, 1, 6, 32'h6, 1, 14, 32'hE, 1, 9, f);
    chk("t6_rst_pend", 64'(bus.pendingMask), 64'd0);
    chk("t6_rst_tw", 64'(bus.toWrite), 64'd0);

    // Random traffic: loads held until accepted, ALU obeys aluHold
    lv = 1'b0; la = '0; ld = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!lv && ($urandom_range(0, 2) != 0)) begin
        lv = 1'b1;
        la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        ld = $urandom;
      end
      step(($urandom_range(0, 199) == 0),
           !bus.aluHold && ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
           lv, la, ld,
           ($urandom_range(0, 2) == 0), 5'($urandom), f);
      if (f || rst) lv = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
